// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port storage array with a sequential init sweep,
// write-through bypass, an optional hardwired zero entry and a signed
// saturating read-modify-write used for perceptron training.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | sweep writes the fill value into one entry per cycle; reads give 0
//   READY | normal operation; reads, writes and init requests are honoured
module reg_file_mp #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 32,
    parameter int               ADDR_WIDTH = $clog2(DEPTH),
    parameter int               NUM_RD     = 2,
    parameter int               INIT_MODE  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    parameter int               BYPASS     = 1,
    parameter int               ZERO_REG   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init_req,
    input  logic                         wr_en,
    input  logic                         wr_op,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]      rd_data,
    output logic                         busy,
    output logic                         init_done
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    // One extra bit so a power-of-two DEPTH still fits for the range compare.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0]      SAT_MAX   = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0]      SAT_MIN   = {1'b1, {(WIDTH - 1){1'b0}}};

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [WIDTH-1:0]        mem [DEPTH];

    logic                    wr_ok;
    logic [WIDTH-1:0]        wr_cur;
    logic [WIDTH:0]          wr_sum;
    logic [WIDTH-1:0]        wr_sat;
    logic [WIDTH-1:0]        wres;
    logic [WIDTH-1:0]        fill;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_EXT);
    endfunction

    function automatic logic is_zero_entry(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Write qualification and the write result, including signed saturation.
    always_comb begin
        wr_ok  = wr_en && (state == ST_READY) && in_range(wr_addr) && !is_zero_entry(wr_addr);
        wr_cur = in_range(wr_addr) ? mem[wr_addr] : '0;
        wr_sum = {wr_cur[WIDTH-1], wr_cur} + {wr_data[WIDTH-1], wr_data};
        // The two top bits of the widened sum disagree only on overflow.
        if (wr_sum[WIDTH] != wr_sum[WIDTH-1]) begin
            wr_sat = wr_sum[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            wr_sat = wr_sum[WIDTH-1:0];
        end
        wres = wr_op ? wr_sat : wr_data;
    end

    // Fill value written by the init sweep for the current entry.
    always_comb begin
        case (INIT_MODE)
            0:       fill = '0;
            1:       fill = '1;
            2:       fill = INIT_VAL;
            default: fill = WIDTH'(init_cnt);
        endcase
    end

    // Sweep / ready sequencing with registered busy and init_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_IDX) begin
                        state     <= ST_READY;
                        init_cnt  <= '0;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        init_done <= 1'b0;
                    end
                end
                ST_READY: begin
                    init_done <= 1'b0;
                    if (init_req) begin
                        state    <= ST_INIT;
                        init_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array update: the sweep owns the array in INIT, user writes in READY.
    // Storage has no reset; contents are defined once the sweep completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= fill;
            end else if (wr_ok) begin
                mem[wr_addr] <= wres;
            end
        end
    end

    // Combinational read ports with write-through bypass; zero while busy.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        rd_data = '0;
        ra      = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (!busy && in_range(ra) && !is_zero_entry(ra)) begin
                if ((BYPASS != 0) && wr_ok && (ra == wr_addr)) begin
                    rd_data[p*WIDTH +: WIDTH] = wres;
                end else begin
                    rd_data[p*WIDTH +: WIDTH] = mem[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: four instances share one stimulus stream and are
// compared against a table-level model (array contents plus remaining sweep
// cycles) and against fixed expected values for the directed scenarios.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  init_req;
    logic        wr_en;
    logic        wr_op;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  rd_addr;
    logic [15:0] rd_all [4];
    logic [3:0]  busy_v;
    logic [3:0]  done_v;

    int checks = 0;
    int errors = 0;

    // Instance configurations: a = index fill + bypass, b = index fill no bypass,
    // c = constant 0x3C fill + bypass, d = zero entry with DEPTH 6.
    int         cfg_depth [4] = '{8, 8, 8, 6};
    bit         cfg_byp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit         cfg_zero  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         cfg_mode  [4] = '{3, 3, 2, 3};
    logic [7:0] cfg_ival  [4] = '{8'h00, 8'h00, 8'h3C, 8'h00};

    logic [7:0] m_mem  [4][8];
    int         m_left [4] = '{8, 8, 8, 6};
    bit         m_done [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    logic [7:0] sat_init  [3] = '{8'h7E, 8'h81, 8'h10};
    logic [7:0] sat_delta [3] = '{8'h05, 8'hF0, 8'hF8};
    logic [7:0] sat_exp   [3] = '{8'h7F, 8'h80, 8'h08};

    always #5 clk = ~clk;

    reg_file_mp #(.WIDTH(8), .DEPTH(8), .NUM_RD(2), .INIT_MODE(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(reset), .init_req(init_req[0]), .wr_en(wr_en), .wr_op(wr_op),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_all[0]),
        .busy(busy_v[0]), .init_done(done_v[0]));

    reg_file_mp #(.WIDTH(8), .DEPTH(8), .NUM_RD(2), .INIT_MODE(3), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .init_req(init_req[1]), .wr_en(wr_en), .wr_op(wr_op),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_all[1]),
        .busy(busy_v[1]), .init_done(done_v[1]));

    reg_file_mp #(.WIDTH(8), .DEPTH(8), .NUM_RD(2), .INIT_MODE(2), .INIT_VAL(8'h3C), .BYPASS(1), .ZERO_REG(0)) dut_c (
        .clk(clk), .reset(reset), .init_req(init_req[2]), .wr_en(wr_en), .wr_op(wr_op),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_all[2]),
        .busy(busy_v[2]), .init_done(done_v[2]));

    reg_file_mp #(.WIDTH(8), .DEPTH(6), .NUM_RD(2), .INIT_MODE(3), .BYPASS(1), .ZERO_REG(1)) dut_d (
        .clk(clk), .reset(reset), .init_req(init_req[3]), .wr_en(wr_en), .wr_op(wr_op),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_all[3]),
        .busy(busy_v[3]), .init_done(done_v[3]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] fill_of(int i, int idx);
        case (cfg_mode[i])
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return cfg_ival[i];
            default: return idx[7:0];
        endcase
    endfunction

    function automatic bit write_hits(int i);
        return wr_en && (int'(wr_addr) < cfg_depth[i]) && !(cfg_zero[i] && wr_addr == 3'd0);
    endfunction

    function automatic logic [7:0] wres_of(int i);
        int s;
        if (!wr_op) return wr_data;
        s = int'($signed(m_mem[i][wr_addr])) + int'($signed(wr_data));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    function automatic logic [7:0] exp_rd(int i, int p);
        int a;
        a = int'(rd_addr[p*3 +: 3]);
        if (m_left[i] > 0) return 8'h00;
        if (a >= cfg_depth[i]) return 8'h00;
        if (cfg_zero[i] && a == 0) return 8'h00;
        if (cfg_byp[i] && wr_en && a == int'(wr_addr)) return wres_of(i);
        return m_mem[i][a];
    endfunction

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_left[i] = cfg_depth[i];
                m_done[i] = 1'b0;
            end else if (m_left[i] > 0) begin
                m_mem[i][cfg_depth[i] - m_left[i]] = fill_of(i, cfg_depth[i] - m_left[i]);
                m_left[i] = m_left[i] - 1;
                m_done[i] = (m_left[i] == 0);
            end else begin
                m_done[i] = 1'b0;
                if (write_hits(i)) m_mem[i][wr_addr] = wres_of(i);
                if (init_req[i]) m_left[i] = cfg_depth[i];
            end
        end
    endtask

    // Advance one clock: model updates at the edge, bench resumes at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; init_req = 4'h0; wr_en = 1'b0; wr_op = 1'b0;
        wr_addr = 3'd0; wr_data = 8'h00; rd_addr = {3'd7, 3'd5};
        tick(); tick(); tick();
        checks++;
        if (busy_v !== 4'hF) begin errors++; $display("FAIL reset_busy: got %b expected 1111", busy_v); end
        checks++;
        if (done_v !== 4'h0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done_v); end
        checks++;
        if (rd_all[0] !== 16'h0000) begin errors++; $display("FAIL reset_rd: got %h expected 0000", rd_all[0]); end
        reset = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            checks++;
            if (busy_v[0] !== (c < 8)) begin
                errors++; $display("FAIL sweep_busy c=%0d: got %b expected %b", c, busy_v[0], (c < 8));
            end
            checks++;
            if (done_v[0] !== (c == 8)) begin
                errors++; $display("FAIL sweep_done c=%0d: got %b expected %b", c, done_v[0], (c == 8));
            end
            if (c < 8) begin
                checks++;
                if (rd_all[0] !== 16'h0000) begin
                    errors++; $display("FAIL busy_rd c=%0d: got %h expected 0000", c, rd_all[0]);
                end
            end
        end
        checks++;
        if (rd_all[0] !== 16'h0705) begin errors++; $display("FAIL index_fill: got %h expected 0705", rd_all[0]); end
    endtask

    task automatic test_bypass();
        rd_addr = {3'd3, 3'd3}; wr_en = 1'b1; wr_op = 1'b0; wr_addr = 3'd3; wr_data = 8'hA5;
        #1;
        checks++;
        if (rd_all[0] !== 16'hA5A5) begin errors++; $display("FAIL bypass_same: got %h expected A5A5", rd_all[0]); end
        checks++;
        if (rd_all[1] !== 16'h0303) begin errors++; $display("FAIL nobypass_same: got %h expected 0303", rd_all[1]); end
        checks++;
        if (rd_all[2] !== 16'hA5A5) begin errors++; $display("FAIL bypass_c_same: got %h expected A5A5", rd_all[2]); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_all[0] !== 16'hA5A5) begin errors++; $display("FAIL bypass_next: got %h expected A5A5", rd_all[0]); end
        checks++;
        if (rd_all[1] !== 16'hA5A5) begin errors++; $display("FAIL nobypass_next: got %h expected A5A5", rd_all[1]); end
    endtask

    task automatic test_saturation();
        rd_addr = {3'd2, 3'd2}; wr_addr = 3'd2;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_op = 1'b0; wr_data = sat_init[k];
            tick();
            wr_op = 1'b1; wr_data = sat_delta[k];
            #1;
            checks++;
            if (rd_all[0][7:0] !== sat_exp[k]) begin
                errors++; $display("FAIL sat_bypass k=%0d: got %h expected %h", k, rd_all[0][7:0], sat_exp[k]);
            end
            checks++;
            if (rd_all[1][7:0] !== sat_init[k]) begin
                errors++; $display("FAIL sat_old k=%0d: got %h expected %h", k, rd_all[1][7:0], sat_init[k]);
            end
            tick();
            wr_en = 1'b0; wr_op = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_all[i] !== {sat_exp[k], sat_exp[k]}) begin
                    errors++; $display("FAIL sat_store k=%0d i=%0d: got %h expected %h%h", k, i, rd_all[i], sat_exp[k], sat_exp[k]);
                end
            end
        end
    endtask

    task automatic test_init_req();
        rd_addr = {3'd1, 3'd1}; wr_en = 1'b1; wr_op = 1'b0; wr_addr = 3'd1; wr_data = 8'h5A;
        init_req = 4'b0100;
        #1;
        checks++;
        if (rd_all[2] !== 16'h5A5A) begin errors++; $display("FAIL initreq_write: got %h expected 5A5A", rd_all[2]); end
        tick();
        init_req = 4'h0;
        checks++;
        if (rd_all[0] !== 16'h5A5A) begin errors++; $display("FAIL initreq_write_a: got %h expected 5A5A", rd_all[0]); end
        rd_addr = {3'd4, 3'd4}; wr_addr = 3'd4; wr_data = 8'h99;
        for (int c = 1; c <= 8; c++) begin
            wr_en = c[0];
            #1;
            checks++;
            if (busy_v[2] !== 1'b1) begin errors++; $display("FAIL initreq_busy c=%0d: got %b expected 1", c, busy_v[2]); end
            checks++;
            if (rd_all[2] !== 16'h0000) begin errors++; $display("FAIL initreq_rd c=%0d: got %h expected 0000", c, rd_all[2]); end
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b1) begin
            errors++; $display("FAIL initreq_end: got busy %b done %b expected busy 0 done 1", busy_v[2], done_v[2]);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = {3'(2 * a + 1), 3'(2 * a)};
            #1;
            checks++;
            if (rd_all[2] !== 16'h3C3C) begin errors++; $display("FAIL const_fill a=%0d: got %h expected 3C3C", a, rd_all[2]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_sweep();
        int pulses;
        pulses = 0;
        init_req = 4'hF;
        tick();
        init_req = 4'h0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (done_v[0]) pulses++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got busy %b done %b expected busy 1 done 0", busy_v[0], done_v[0]);
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (done_v[0]) pulses++;
            checks++;
            if (busy_v[0] !== (c < 8)) begin
                errors++; $display("FAIL midreset_busy c=%0d: got %b expected %b", c, busy_v[0], (c < 8));
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL midreset_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_zero_reg();
        rd_addr = {3'd0, 3'd0}; wr_en = 1'b1; wr_op = 1'b0; wr_addr = 3'd0; wr_data = 8'hFF;
        #1;
        checks++;
        if (rd_all[3] !== 16'h0000) begin errors++; $display("FAIL zero_nobypass: got %h expected 0000", rd_all[3]); end
        checks++;
        if (rd_all[0] !== 16'hFFFF) begin errors++; $display("FAIL zero_ref_bypass: got %h expected FFFF", rd_all[0]); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_all[3] !== 16'h0000) begin errors++; $display("FAIL zero_after: got %h expected 0000", rd_all[3]); end
        rd_addr = {3'd7, 3'd6}; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h77;
        #1;
        checks++;
        if (rd_all[3] !== 16'h0000) begin errors++; $display("FAIL oob_write_rd: got %h expected 0000", rd_all[3]); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_all[3] !== 16'h0000) begin errors++; $display("FAIL oob_rd: got %h expected 0000", rd_all[3]); end
        for (int a = 0; a < 3; a++) begin
            rd_addr = {3'(2 * a + 1), 3'(2 * a)};
            #1;
            checks++;
            if (rd_all[3] !== {exp_rd(3, 1), exp_rd(3, 0)}) begin
                errors++; $display("FAIL zero_contents a=%0d: got %h expected %h%h", a, rd_all[3], exp_rd(3, 1), exp_rd(3, 0));
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) init_req[i] = ($urandom_range(0, 39) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_op   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            rd_addr = 6'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[2:0] = wr_addr;
            #1;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (busy_v[i] !== (m_left[i] > 0)) begin
                    errors++; $display("FAIL rnd_busy n=%0d i=%0d: got %b expected %b", n, i, busy_v[i], (m_left[i] > 0));
                end
                checks++;
                if (done_v[i] !== m_done[i]) begin
                    errors++; $display("FAIL rnd_done n=%0d i=%0d: got %b expected %b", n, i, done_v[i], m_done[i]);
                end
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (rd_all[i][p*8 +: 8] !== exp_rd(i, p)) begin
                        errors++; $display("FAIL rnd_rd n=%0d i=%0d p=%0d: got %h expected %h", n, i, p, rd_all[i][p*8 +: 8], exp_rd(i, p));
                    end
                end
            end
            tick();
        end
        init_req = 4'h0;
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; init_req = 4'h0; wr_en = 1'b0; wr_op = 1'b0;
        wr_addr = 3'd0; wr_data = 8'h00; rd_addr = 6'd0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_saturation();
        test_init_req();
        test_reset_mid_sweep();
        test_zero_reg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port storage array for the pipeline: architectural register file and perceptron weight/history tables.
- Adds several capabilities:
  - configurable read-port count;
  - write-through bypass;
  - hardwired zero entry;
  - signed saturating read-modify-write for perceptron training;
  - sequential init sweep, one entry per cycle, so large tables need no single-cycle reset fan-out.

Parameters:
- WIDTH, 8, bits per entry.
- DEPTH, 32, number of entries; any value ≥ 2 is legal.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_RD, 2, number of combinational read ports (1..4).
- INIT_MODE, 0, sweep fill value: 0 = zero, 1 = all-ones, 2 = INIT_VAL, 3 = entry index (truncated/zero-extended to WIDTH).
- INIT_VAL, 0, fill value used when INIT_MODE = 2.
- BYPASS, 1, 1 = same-cycle write-through to read ports.
- ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- init_req  input  1  starts an init sweep when the block is READY.
- wr_en  input  1  write strobe.
- wr_op  input  1  0 = overwrite, 1 = signed saturating add of wr_data to the stored entry.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  WIDTH  write data, or signed delta when wr_op = 1.
- rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NUM_RD*WIDTH  packed read data, same packing as rd_addr.
- busy  output  1  high while reset is asserted or an init sweep is running.
- init_done  output  1  one-cycle pulse after the last sweep write.

Behaviour:
- States: INIT, READY. init_cnt is ADDR_WIDTH bits.
- Reset:
  - While reset = 1: state = INIT, init_cnt = 0, busy = 1, init_done = 0. No array writes occur during reset.
  - The array is undefined until the sweep completes.
- INIT state:
  - Each cycle, entry[init_cnt] <= fill value, then init_cnt increments.
  - When init_cnt == DEPTH-1, the write occurs, state -> READY and init_done = 1 for exactly that next cycle.
  - Sweep takes DEPTH cycles after reset deasserts; busy falls on cycle DEPTH.
  - Inside INIT, wr_en and init_req are ignored and writes are dropped (not queued).
  - rd_data = 0 on all ports while busy = 1.
  - Reset asserted mid-sweep restarts the sweep at 0 after deassertion.
- READY state:
  - init_req = 1 -> INIT next cycle with init_cnt = 0 and busy = 1.
  - If init_req and wr_en are high in the same cycle, the write is performed in that cycle and the sweep starts next cycle.
- Reads: combinational, zero latency. rd_data[p] = entry[rd_addr[p]], subject to the bypass and zero-reg rules below.
- Write result (wres):
  - wr_op = 0: wres = wr_data.
  - wr_op = 1: wres = sat(entry[wr_addr] + wr_data), operands signed two's-complement WIDTH.
  - The sum is formed at WIDTH+1 bits and clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - entry[wr_addr] <= wres on the clock edge when wr_en = 1 and state = READY.
- Bypass:
  - Applies when BYPASS = 1, state = READY, wr_en = 1 and rd_addr[p] == wr_addr.
  - rd_data[p] = wres in the same cycle; every matching port is bypassed.
  - With BYPASS = 0, reads return the pre-write value until the next cycle.
- ZERO_REG = 1:
  - Reads of address 0 return 0, with no bypass.
  - Writes to address 0 are discarded.
  - The sweep still writes entry 0; this is harmless.
- Addresses ≥ DEPTH (non-power-of-2 DEPTH):
  - Writes are ignored.
  - Reads return 0.
- No combinational path exists from reset or init_req to rd_data other than through the registered busy/state.

Test Plan (WIDTH = 8, DEPTH = 8, NUM_RD = 2 unless noted):
- Reset, then deassert, INIT_MODE = 3:
  - busy stays 1 for cycles 0..7 after deassertion, init_done pulses at cycle 8, busy = 0.
  - Reading addresses 5 and 7 returns 0x05 and 0x07.
- READY, write addr 3 = 0xA5 while reading port0 = 3 and port1 = 3, BYPASS = 1:
  - Both ports show 0xA5 in the same cycle, and again on the next cycle.
  - Repeat with BYPASS = 0: both ports show the old value (0x03) in the write cycle and 0xA5 the next.
- Saturation on entry 2:
  - Set entry 2 = 0x7E, then wr_op = 1 with wr_data = 0x05 -> entry = 0x7F.
  - Set entry 2 = 0x81, then wr_data = 0xF0 -> entry = 0x80.
  - Set entry 2 = 0x10, then wr_data = 0xF8 -> entry = 0x08.
- init_req with INIT_MODE = 2 and INIT_VAL = 0x3C:
  - The write issued in the same cycle as init_req lands.
  - The sweep then overwrites all 8 entries with 0x3C in 8 cycles.
  - wr_en pulses during the sweep are dropped and rd_data reads 0 while busy.
- Reset asserted for 1 cycle at sweep cycle 4:
  - Sweep restarts; busy remains high for a full 8 cycles after deassertion.
  - Exactly one init_done pulse follows.
- ZERO_REG = 1, DEPTH = 6:
  - Write 0xFF to addr 0 -> reads 0; no bypass in the write cycle.
  - Write addr 6 -> no array change.
  - Read addr 7 -> 0.
